score_counter: RTL and testbench
================================

# score_counter

Game-side score keeper feeding `score_print`. Turns point events from game logic into two saturating packed-BCD scores and detects the winner. It presents frame-stable score snapshots, updated only on `frame_start`, so the pixel renderer never shows a torn value mid-frame. One instance per playfield, clocked by the pixel clock domain used by the renderer.

## Interface
Parameters:
- `DIGITS`, 3, BCD digits per player score; output width is 4*DIGITS.
- `WIN`, 11, binary winning score; 0 disables win detection.

Ports:
- `clk`  in  1  system/pixel clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `frame_start`  in  1  one-cycle strobe at start of vertical blanking.
- `point_a`  in  1  player A point request; rising edge counts.
- `point_b`  in  1  player B point request; rising edge counts.
- `clear`  in  1  synchronous new-game request (level, sampled each cycle).
- `score_a`  out  4*DIGITS  frame-stable packed BCD score A, digit 0 in bits [3:0].
- `score_b`  out  4*DIGITS  frame-stable packed BCD score B.
- `winner`  out  2  live: 00 none, 01 A, 10 B, 11 draw.

## Operation
- Edge detect: `prev_a`/`prev_b` registers; event when input high and prev low. Prev registers reset to 1, so an input held high through reset does not score.
- Live counters per player: packed BCD value plus binary shadow, width clog2(10^DIGITS).
- BCD increment: digit 9 -> 0 with carry into next digit; ripple through all DIGITS in one cycle.
- Saturation: at all-nines (e.g. 999), increment is dropped; value and shadow hold.
- FSM states PLAY and WON:
  - PLAY: events increment. If WIN != 0 and a shadow reaches WIN after update, go to WON and set `winner`. Both reaching WIN in the same cycle gives `winner`=11.
  - WON: point events are ignored; counters frozen.
  - Any state: `clear`=1 zeroes live counters, sets `winner`=00, returns to PLAY.
- Simultaneous A and B events in PLAY: both increment in the same cycle.
- `clear` with a point event in the same cycle: clear wins and the event is dropped. Prev registers still update, so the edge is consumed.
- Snapshot: on `frame_start`=1, `score_a`/`score_b` load the live counters' current registered values, i.e. pre-update values for that cycle.
- `clear` does not touch snapshots; zeros appear at the next `frame_start`.

## Timing
- Reset values: `score_a`=0, `score_b`=0, `winner`=00, state PLAY, live counters 0, prev regs 1.
- Live counter update: event sampled at edge k, new live value after edge k.
- Display latency: visible after the first `frame_start` edge j with j > k.
  - If `frame_start` coincides with edge k, the old value is shown until the next frame.
- `winner` latency: asserted after the same edge k that produced the winning count. It is not snapshot-gated.
- Reset mid-game overrides all inputs that cycle.
- Back-to-back rising edges need a low cycle between them. A pulse held high counts once.

## Configuration
- `SCORE_HISCORE_EN` defined:
  - Adds output `hiscore` [4*DIGITS-1:0], packed BCD, reset 0 by `rst` only.
  - On the WON entry edge, and on a `clear` edge, `hiscore` loads the max of itself, live A and live B (compared via shadows).
  - Updates immediately, not frame-gated.
- Undefined: no `hiscore` port and no related logic.

## Test plan
- Reset with `point_a` held high, release `rst` -> no increment. Drop `point_a` then raise it -> live A = 001; `score_a` stays 000 until `frame_start`, then reads 12'h001.
- 10 A pulses with WIN=0, then `frame_start` -> `score_a`=12'h010, showing carry into digit 1.
- WIN=0, 999 A pulses, then one more pulse and `frame_start` -> `score_a`=12'h999; saturation holds.
- WIN=11, A and B both at 10, rising edges on both in the same cycle -> `winner`=11. Next A pulse -> no change. Assert `clear` -> `winner`=00, next-frame scores 000.
- `frame_start` in the same cycle as an A edge -> snapshot shows the old value; the next `frame_start` shows the incremented one.
- With `SCORE_HISCORE_EN`: A wins at 11, then `clear`, then B reaches 5, then `clear` -> `hiscore`=12'h011. `rst` -> 0.

Source files
------------

// File: rtl/score_if.sv
// Point/clear/frame inputs and frame-stable score outputs of score_counter.
// SCORE_HISCORE_EN adds the hiscore output.
interface score_if #(
  parameter int DIGITS = 3
);
  logic                  frame_start;
  logic                  point_a;
  logic                  point_b;
  logic                  clear;
  logic [4*DIGITS-1:0]   score_a;
  logic [4*DIGITS-1:0]   score_b;
  logic [1:0]            winner;
`ifdef SCORE_HISCORE_EN
  logic [4*DIGITS-1:0]   hiscore;

  modport master (
    output frame_start, point_a, point_b, clear,
    input  score_a, score_b, winner, hiscore
  );
  modport slave (
    input  frame_start, point_a, point_b, clear,
    output score_a, score_b, winner, hiscore
  );
`else
  modport master (
    output frame_start, point_a, point_b, clear,
    input  score_a, score_b, winner
  );
  modport slave (
    input  frame_start, point_a, point_b, clear,
    output score_a, score_b, winner
  );
`endif
endinterface

// File: rtl/score_counter.sv
// Saturating packed-BCD two-player score keeper with frame-stable snapshots.
// SCORE_HISCORE_EN adds a running high-score register.
module score_counter #(
  parameter int DIGITS = 3,
  parameter int WIN    = 11
) (
  input  logic   clk,
  input  logic   rst,
  score_if.slave bus
);
  localparam int W    = 4 * DIGITS;
  localparam int MAXV = 10 ** DIGITS - 1;
  localparam int SW   = $clog2(10 ** DIGITS);

  typedef enum logic {PLAY, WON} state_e;

  state_e        state_q, state_d;
  logic          prev_a_q, prev_a_d;
  logic          prev_b_q, prev_b_d;
  logic [W-1:0]  bcd_a_q, bcd_a_d;
  logic [W-1:0]  bcd_b_q, bcd_b_d;
  logic [SW-1:0] sh_a_q, sh_a_d;
  logic [SW-1:0] sh_b_q, sh_b_d;
  logic [W-1:0]  snap_a_q, snap_a_d;
  logic [W-1:0]  snap_b_q, snap_b_d;
  logic [1:0]    win_q, win_d;
  logic          ev_a, ev_b;
  logic          reach_a, reach_b;

  function automatic logic [W-1:0] bcd_inc(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign ev_a = bus.point_a & ~prev_a_q;
  assign ev_b = bus.point_b & ~prev_b_q;

  always_comb begin
    prev_a_d = bus.point_a;
    prev_b_d = bus.point_b;
    bcd_a_d  = bcd_a_q;
    bcd_b_d  = bcd_b_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    win_d    = win_q;
    state_d  = state_q;
    reach_a  = 1'b0;
    reach_b  = 1'b0;
    // Snapshots take the pre-update live values.
    if (bus.frame_start) begin
      snap_a_d = bcd_a_q;
      snap_b_d = bcd_b_q;
    end
    if (bus.clear) begin
      bcd_a_d = '0;
      bcd_b_d = '0;
      sh_a_d  = '0;
      sh_b_d  = '0;
      win_d   = 2'b00;
      state_d = PLAY;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (ev_a && sh_a_q != SW'(MAXV)) begin
            bcd_a_d = bcd_inc(bcd_a_q);
            sh_a_d  = sh_a_q + SW'(1);
          end
          if (ev_b && sh_b_q != SW'(MAXV)) begin
            bcd_b_d = bcd_inc(bcd_b_q);
            sh_b_d  = sh_b_q + SW'(1);
          end
          reach_a = (WIN != 0) && (int'(sh_a_d) == WIN);
          reach_b = (WIN != 0) && (int'(sh_b_d) == WIN);
          if (reach_a || reach_b) begin
            state_d = WON;
            win_d   = {reach_b, reach_a};
          end
        end
        WON: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PLAY;
      prev_a_q <= 1'b1;
      prev_b_q <= 1'b1;
      bcd_a_q  <= '0;
      bcd_b_q  <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      snap_a_q <= '0;
      snap_b_q <= '0;
      win_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      prev_a_q <= prev_a_d;
      prev_b_q <= prev_b_d;
      bcd_a_q  <= bcd_a_d;
      bcd_b_q  <= bcd_b_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      snap_a_q <= snap_a_d;
      snap_b_q <= snap_b_d;
      win_q    <= win_d;
    end
  end

  assign bus.score_a = snap_a_q;
  assign bus.score_b = snap_b_q;
  assign bus.winner  = win_q;

`ifdef SCORE_HISCORE_EN
  logic [W-1:0]  hi_q, hi_d;
  logic [SW-1:0] hi_sh_q, hi_sh_d;
  logic [W-1:0]  src_a, src_b;
  logic [SW-1:0] src_sa, src_sb;

  // Clear sees the outgoing game, a win sees the winning count.
  always_comb begin
    hi_d    = hi_q;
    hi_sh_d = hi_sh_q;
    src_a   = bus.clear ? bcd_a_q : bcd_a_d;
    src_b   = bus.clear ? bcd_b_q : bcd_b_d;
    src_sa  = bus.clear ? sh_a_q : sh_a_d;
    src_sb  = bus.clear ? sh_b_q : sh_b_d;
    if (bus.clear || (state_q == PLAY && state_d == WON)) begin
      if (src_sa > hi_sh_d) begin
        hi_d    = src_a;
        hi_sh_d = src_sa;
      end
      if (src_sb > hi_sh_d) begin
        hi_d    = src_b;
        hi_sh_d = src_sb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= '0;
      hi_sh_q <= '0;
    end else begin
      hi_q    <= hi_d;
      hi_sh_q <= hi_sh_d;
    end
  end

  assign bus.hiscore = hi_q;
`endif
endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: WIN=0 and WIN=11 instances vs an integer model.
// Checks hiscore as well when SCORE_HISCORE_EN is defined.
module tb_score_counter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_if #(.DIGITS(3)) if0 ();
  score_if #(.DIGITS(3)) if1 ();

  score_counter #(.DIGITS(3), .WIN(0)) u_w0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  score_counter #(.DIGITS(3), .WIN(11)) u_w11 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_win [2] = '{0, 11};
  int la [2], lb [2], sa [2], sb [2], wn [2], hi [2];
  bit pa_q [2], pb_q [2], won [2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic [11:0] bcd(input int v);
    return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  task automatic mstep(input int i, input bit r, input bit f,
                       input bit a, input bit b, input bit c);
    bit ea, eb;
    if (r) begin
      la[i] = 0; lb[i] = 0; sa[i] = 0; sb[i] = 0;
      wn[i] = 0; hi[i] = 0; won[i] = 0;
      pa_q[i] = 1; pb_q[i] = 1;
    end else begin
      ea = a && !pa_q[i];
      eb = b && !pb_q[i];
      if (f) begin
        sa[i] = la[i];
        sb[i] = lb[i];
      end
      if (c) begin
        hi[i] = imax(hi[i], imax(la[i], lb[i]));
        la[i] = 0; lb[i] = 0; wn[i] = 0; won[i] = 0;
      end else if (!won[i]) begin
        if (ea && la[i] < 999) la[i]++;
        if (eb && lb[i] < 999) lb[i]++;
        if (m_win[i] != 0 && (la[i] == m_win[i] || lb[i] == m_win[i])) begin
          won[i] = 1;
          wn[i] = (la[i] == m_win[i] ? 1 : 0) + (lb[i] == m_win[i] ? 2 : 0);
          hi[i] = imax(hi[i], imax(la[i], lb[i]));
        end
      end
      pa_q[i] = a;
      pb_q[i] = b;
    end
  endtask

  task automatic cyc(input bit r, input bit f, input bit a,
                     input bit b, input bit c);
    rst = r;
    if0.frame_start = f; if1.frame_start = f;
    if0.point_a = a;     if1.point_a = a;
    if0.point_b = b;     if1.point_b = b;
    if0.clear = c;       if1.clear = c;
    @(posedge clk);
    for (int i = 0; i < 2; i++) mstep(i, r, f, a, b, c);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("score_a/w%0d", m_win[i]),
            32'(i == 0 ? if0.score_a : if1.score_a), 32'(bcd(sa[i])));
      check($sformatf("score_b/w%0d", m_win[i]),
            32'(i == 0 ? if0.score_b : if1.score_b), 32'(bcd(sb[i])));
      check($sformatf("winner/w%0d", m_win[i]),
            32'(i == 0 ? if0.winner : if1.winner), 32'(wn[i]));
`ifdef SCORE_HISCORE_EN
      check($sformatf("hiscore/w%0d", m_win[i]),
            32'(i == 0 ? if0.hiscore : if1.hiscore), 32'(bcd(hi[i])));
`endif
    end
  endtask

  task automatic pulse(input bit a, input bit b);
    cyc(0, 0, a, b, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Held-high point through reset must not score.
    repeat (3) cyc(1, 0, 1, 0, 0);
    check("rst_score_a", 32'(if0.score_a), 32'h000);
    check("rst_winner", 32'(if1.winner), 32'h0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("held_high", 32'(if0.score_a), 32'h000);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("pre_frame", 32'(if0.score_a), 32'h000);
    cyc(0, 1, 0, 0, 0);
    check("first_pt", 32'(if0.score_a), 32'h001);

    // Carry into digit 1.
    cyc(0, 0, 0, 0, 1);
    repeat (10) pulse(1, 0);
    cyc(0, 1, 0, 0, 0);
    check("carry", 32'(if0.score_a), 32'h010);
    check("no_win_10", 32'(if1.winner), 32'h0);

    // Draw at 11, frozen after win, clear.
    cyc(0, 0, 0, 0, 1);
    repeat (10) pulse(1, 1);
    check("pre_draw", 32'(if1.winner), 32'h0);
    pulse(1, 1);
    check("draw", 32'(if1.winner), 32'h3);
    check("w0_nowin", 32'(if0.winner), 32'h0);
    pulse(1, 0);
    cyc(0, 1, 0, 0, 0);
    check("frozen", 32'(if1.score_a), 32'h011);
    check("w0_run", 32'(if0.score_a), 32'h012);
    cyc(0, 0, 0, 0, 1);
    check("clr_win", 32'(if1.winner), 32'h0);
    check("clr_snap", 32'(if1.score_a), 32'h011);
    cyc(0, 1, 0, 0, 0);
    check("clr_a", 32'(if1.score_a), 32'h000);
    check("clr_b", 32'(if1.score_b), 32'h000);

    // Frame strobe coinciding with a point.
    cyc(0, 1, 1, 0, 0);
    check("fs_same", 32'(if0.score_a), 32'h000);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("fs_next", 32'(if0.score_a), 32'h001);

    // Clear beats a same-cycle point and consumes the edge.
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("clr_edge", 32'(if0.score_a), 32'h000);

    // Saturation at 999.
    repeat (1000) pulse(1, 0);
    cyc(0, 1, 0, 0, 0);
    check("sat", 32'(if0.score_a), 32'h999);
    check("a_wins", 32'(if1.winner), 32'h1);
    pulse(1, 0);
    cyc(0, 1, 0, 0, 0);
    check("sat_hold", 32'(if0.score_a), 32'h999);

    // Reset overrides everything.
    cyc(1, 1, 1, 1, 1);
    check("midrst", 32'(if0.score_a), 32'h000);

`ifdef SCORE_HISCORE_EN
    cyc(0, 0, 0, 0, 1);
    repeat (11) pulse(1, 0);
    check("hi_won", 32'(if1.hiscore), 32'h011);
    cyc(0, 0, 0, 0, 1);
    repeat (5) pulse(0, 1);
    cyc(0, 0, 0, 0, 1);
    check("hi_keep", 32'(if1.hiscore), 32'h011);
    cyc(1, 0, 0, 0, 0);
    check("hi_rst", 32'(if1.hiscore), 32'h000);
`endif

    repeat (3000) begin
      cyc(1'($urandom_range(499) == 0), 1'($urandom_range(7) == 0),
          1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(127) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
